// File: rtl/frame_stream_pkg.sv
// Shared FSM encoding and width helpers for the frame stream reader.
package frame_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LINE,
        S_HBLANK,
        S_DONE
    } state_t;

    function automatic int fsr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_stream_reader.sv
// Streams one frame from a linear frame memory as a data_en/pixel_out raster.
// Define FRAME_STREAM_READER_PATTERN_EN to replace memory data with an (x+y) ramp.
module frame_stream_reader
    import frame_stream_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int HBLANK     = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      abort,
    output logic                                      mem_rd_en,
    output logic [fsr_width(IMG_WIDTH*IMG_HEIGHT)-1:0] mem_addr,
    input  logic [7:0]                                mem_rd_data,
    output logic                                      data_en,
    output logic [7:0]                                pixel_out,
    output logic                                      frame_start,
    output logic                                      busy,
    output logic                                      done
);

    localparam int XW = fsr_width(IMG_WIDTH);
    localparam int YW = fsr_width(IMG_HEIGHT);
    localparam int AW = fsr_width(IMG_WIDTH*IMG_HEIGHT);
    localparam int HW = fsr_width(HBLANK);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [HW-1:0] HB_LAST = HW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam bit            HAS_HB  = (HBLANK > 0);

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic [HW-1:0] r_hcnt;
    logic          r_rd_en;
    logic          r_data_en;
    logic [7:0]    r_pixel;
    logic          r_frame_start;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    w_pix;

`ifdef FRAME_STREAM_READER_PATTERN_EN
    // Ramp is taken from the coordinates of the read issued this cycle.
    assign w_pix = 8'(32'(r_x) + 32'(r_y));
`else
    assign w_pix = mem_rd_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_hcnt        <= '0;
            r_rd_en       <= 1'b0;
            r_data_en     <= 1'b0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // An abort also kills the read already in flight.
            r_data_en     <= r_rd_en & ~abort;
            r_frame_start <= r_rd_en & ~abort & (r_addr == '0);
            if (r_rd_en)
                r_pixel <= w_pix;
            r_done <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_LINE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_hcnt  <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LINE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_x == X_LAST) begin
                        r_x <= '0;
                        if (r_y == Y_LAST) begin
                            r_state <= S_DONE;
                            r_rd_en <= 1'b0;
                        end else begin
                            r_y    <= r_y + 1'b1;
                            r_addr <= r_addr + 1'b1;
                            if (HAS_HB) begin
                                r_state <= S_HBLANK;
                                r_hcnt  <= '0;
                                r_rd_en <= 1'b0;
                            end
                        end
                    end else begin
                        r_x    <= r_x + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_HBLANK: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= '0;
                        r_hcnt  <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_hcnt == HB_LAST) begin
                        r_state <= S_LINE;
                        r_hcnt  <= '0;
                        r_rd_en <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= ~abort;
                end
            endcase
        end
    end

    assign mem_rd_en   = r_rd_en;
    assign mem_addr    = r_addr;
    assign data_en     = r_data_en;
    assign pixel_out   = r_pixel;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader at 4x3 with HBLANK=2 and a second HBLANK=0 instance.
module tb_frame_stream_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic          mem_rd_en, data_en, frame_start, busy, done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data, pixel_out;

    logic          start0, abort0;
    logic          mem_rd_en0, data_en0, frame_start0, busy0, done0;
    logic [AW-1:0] mem_addr0;
    logic [7:0]    mem_rd_data0, pixel_out0;

    always #5 clk = ~clk;

    // Asynchronous memory holding value = address; junk when not strobed.
    assign mem_rd_data  = mem_rd_en  ? 8'(mem_addr)  : 8'hEE;
    assign mem_rd_data0 = mem_rd_en0 ? 8'(mem_addr0) : 8'hEE;

    frame_stream_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .data_en(data_en), .pixel_out(pixel_out), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    frame_stream_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .HBLANK(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0), .mem_rd_data(mem_rd_data0),
        .data_en(data_en0), .pixel_out(pixel_out0), .frame_start(frame_start0),
        .busy(busy0), .done(done0)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int sbq[$];
    int q0[$];

    typedef struct {
        bit de;
        int addr;
        bit bsy;
        bit dn;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [7:0] exp_pix(input int a);
`ifdef FRAME_STREAM_READER_PATTERN_EN
        return 8'((a % W) + (a / W));
`else
        return 8'(a);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_frame(input int n);
        for (int a = 0; a < n; a++) sbq.push_back(a);
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL done_timeout: no done within %0d cycles", lim);
        end
    endtask

    int a_mon, a_mon0;
    always @(negedge clk) begin
        if (!rst && data_en) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pixel: got %0h with empty scoreboard", pixel_out);
            end else begin
                a_mon = sbq.pop_front();
                chk("sb_pixel", pixel_out, exp_pix(a_mon));
                chk("sb_frame_start", frame_start, a_mon == 0);
            end
        end
        if (!rst && data_en0) begin
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pixel_hb0: got %0h with empty scoreboard", pixel_out0);
            end else begin
                a_mon0 = q0.pop_front();
                chk("sb0_pixel", pixel_out0, exp_pix(a_mon0));
                chk("sb0_frame_start", frame_start0, a_mon0 == 0);
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        int d0, n;
        tbl = '{
            '{0, 0, 1, 0},
            '{1, 0, 1, 0}, '{1, 1, 1, 0}, '{1, 2, 1, 0}, '{1, 3, 1, 0},
            '{0, 0, 1, 0}, '{0, 0, 1, 0},
            '{1, 4, 1, 0}, '{1, 5, 1, 0}, '{1, 6, 1, 0}, '{1, 7, 1, 0},
            '{0, 0, 1, 0}, '{0, 0, 1, 0},
            '{1, 8, 1, 0}, '{1, 9, 1, 0}, '{1, 10, 1, 0}, '{1, 11, 1, 0},
            '{0, 0, 0, 1},
            '{0, 0, 0, 0}
        };
        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data_en", data_en, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full frame timing against the cycle table.
        start = 1'b1;
        push_frame(W*H);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl%0d_de", i), data_en, tbl[i].de);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            if (tbl[i].de) begin
                chk($sformatf("tbl%0d_pix", i), pixel_out, exp_pix(tbl[i].addr));
                chk($sformatf("tbl%0d_fs", i), frame_start, tbl[i].addr == 0);
            end
        end

        // No horizontal blanking: 12 back-to-back pixels.
        start0 = 1'b1;
        for (int a = 0; a < W*H; a++) q0.push_back(a);
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < W*H; i++) begin
            chk($sformatf("hb0_de%0d", i), data_en0, 1);
            if (i < W*H - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("hb0_de_end", data_en0, 0);
        chk("hb0_q_empty", q0.size(), 0);

        // Start pulses while busy are ignored.
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        start = 1'b1;
        push_frame(W*H);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            start = (i % 3 == 0);
        end
        wait_done(40);
        repeat (4) @(negedge clk);
        chk("busy_start_dones", done_cnt - d0, 1);
        chk("busy_start_q", sbq.size(), 0);
        chk("busy_start_idle", busy, 0);

        // Abort right after pixel 5 is issued.
        d0 = done_cnt;
        start = 1'b1;
        push_frame(5);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_rd_en && mem_addr == 5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(mem_rd_en && mem_addr == 5)) begin
            n_chk++;
            $display("FAIL abort_wait_timeout: addr 5 never issued");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_de", data_en, 0);
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_q", sbq.size(), 0);
        start = 1'b1;
        push_frame(W*H);
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        repeat (2) @(negedge clk);
        chk("abort_restart_q", sbq.size(), 0);
        chk("abort_restart_done", done_cnt - d0, 1);

        // Reset in the middle of a frame.
        start = 1'b1;
        push_frame(W*H);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_rd_en", mem_rd_en, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_de", data_en, 0);
        chk("mrst_pixel", pixel_out, 0);
        chk("mrst_fs", frame_start, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        push_frame(W*H);
        @(negedge clk);
        start = 1'b0;
        chk("mrst_first_addr", mem_addr, 0);
        wait_done(40);
        repeat (2) @(negedge clk);
        chk("mrst_q", sbq.size(), 0);

        // Abort wins over start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_rd_en", mem_rd_en, 0);
        @(negedge clk);
        chk("idle_abort_de", data_en, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
